// File: rtl/touch_pkg.sv
// Shared types and constants for the touch-panel region decoder.
package touch_pkg;

    localparam int MAX_COORD_W = 16;

    localparam logic BANK_NORMAL = 1'b0;
    localparam logic BANK_BATTLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD
    } state_t;

    // Bounds are stored zero-extended to MAX_COORD_W so one record type serves every COORD_W.
    typedef struct packed {
        logic                   en;
        logic [MAX_COORD_W-1:0] xmin;
        logic [MAX_COORD_W-1:0] xmax;
        logic [MAX_COORD_W-1:0] ymin;
        logic [MAX_COORD_W-1:0] ymax;
    } region_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/touch_region_decoder_if.sv
// Sample, region-table configuration and result signals of the touch region decoder.
interface touch_region_decoder_if
    import touch_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int N_REGIONS = 4
);
    localparam int IDX_W = idx_width(N_REGIONS);

    logic               mode;
    logic               touch_valid;
    logic               touch_pen;
    logic [COORD_W-1:0] touch_x;
    logic [COORD_W-1:0] touch_y;

    logic               cfg_we;
    logic               cfg_bank;
    logic [IDX_W-1:0]   cfg_idx;
    logic               cfg_en;
    logic [COORD_W-1:0] cfg_xmin;
    logic [COORD_W-1:0] cfg_xmax;
    logic [COORD_W-1:0] cfg_ymin;
    logic [COORD_W-1:0] cfg_ymax;

    logic [N_REGIONS-1:0] dir;
    logic [IDX_W-1:0]     hit_idx;
    logic                 press;
    // "release" is a reserved word, hence the suffix.
    logic                 release_pulse;

    modport master (
        output mode, touch_valid, touch_pen, touch_x, touch_y,
        output cfg_we, cfg_bank, cfg_idx, cfg_en, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax,
        input  dir, hit_idx, press, release_pulse
    );

    modport slave (
        input  mode, touch_valid, touch_pen, touch_x, touch_y,
        input  cfg_we, cfg_bank, cfg_idx, cfg_en, cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax,
        output dir, hit_idx, press, release_pulse
    );

endinterface

// File: rtl/touch_region_match.sv
// Combinational strict-bounds hit test over one bank, lowest index wins.
module touch_region_match
    import touch_pkg::*;
#(
    parameter int N_REGIONS = 4,
    parameter int IDX_W     = 2
) (
    input  region_t                regions [N_REGIONS],
    input  logic [MAX_COORD_W-1:0] x,
    input  logic [MAX_COORD_W-1:0] y,
    output logic                   hit,
    output logic [IDX_W-1:0]       idx
);

    logic [N_REGIONS-1:0] hits;

    always_comb begin
        hits = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            hits[i] = regions[i].en
                   && (x > regions[i].xmin) && (x < regions[i].xmax)
                   && (y > regions[i].ymin) && (y < regions[i].ymax);
        end
    end

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/touch_region_decoder.sv
// Debounced touch region decoder: two-bank region table, press/release FSM, registered outputs.
module touch_region_decoder
    import touch_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int N_REGIONS = 4,
    parameter int DEBOUNCE  = 4
) (
    input logic                   clk,
    input logic                   rst,
    touch_region_decoder_if.slave bus
);

    localparam int IDX_W = idx_width(N_REGIONS);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    region_t bank_normal [N_REGIONS];
    region_t bank_battle [N_REGIONS];
    region_t bank_sel    [N_REGIONS];
    region_t new_entry;
    logic    cfg_ok;

    assign cfg_ok    = ({1'b0, bus.cfg_idx} < (IDX_W + 1)'(N_REGIONS));
    assign new_entry = '{
        en:   bus.cfg_en,
        xmin: MAX_COORD_W'(bus.cfg_xmin),
        xmax: MAX_COORD_W'(bus.cfg_xmax),
        ymin: MAX_COORD_W'(bus.cfg_ymin),
        ymax: MAX_COORD_W'(bus.cfg_ymax)
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                bank_normal[i] <= '0;
                bank_battle[i] <= '0;
            end
        end else if (bus.cfg_we && cfg_ok) begin
            if (bus.cfg_bank == BANK_NORMAL) begin
                bank_normal[bus.cfg_idx] <= new_entry;
            end else begin
                bank_battle[bus.cfg_idx] <= new_entry;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            bank_sel[i] = (bus.mode == BANK_BATTLE) ? bank_battle[i] : bank_normal[i];
        end
    end

    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             sample_hit;

    touch_region_match #(
        .N_REGIONS (N_REGIONS),
        .IDX_W     (IDX_W)
    ) u_match (
        .regions (bank_sel),
        .x       (MAX_COORD_W'(bus.touch_x)),
        .y       (MAX_COORD_W'(bus.touch_y)),
        .hit     (match_hit),
        .idx     (match_idx)
    );

    assign sample_hit = bus.touch_pen && match_hit;

    function automatic logic [N_REGIONS-1:0] onehot(input logic [IDX_W-1:0] k);
        logic [N_REGIONS-1:0] v;
        for (int i = 0; i < N_REGIONS; i++) begin
            v[i] = (IDX_W'(i) == k);
        end
        return v;
    endfunction

    state_t               state, state_n;
    logic [IDX_W-1:0]     cand, cand_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic                 at_limit;
    logic                 mode_q;
    logic [N_REGIONS-1:0] dir_q, dir_n;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_n;
    logic                 press_q, press_n;
    logic                 release_q, release_n;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign at_limit = (cnt_inc == CNT_W'(DEBOUNCE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            dir_q     <= '0;
            hit_idx_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            mode_q    <= bus.mode;
            dir_q     <= dir_n;
            hit_idx_q <= hit_idx_n;
            press_q   <= press_n;
            release_q <= release_n;
        end
    end

    // In HELD, cnt counts consecutive samples that do not match the committed region.
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        dir_n     = dir_q;
        hit_idx_n = hit_idx_q;
        press_n   = 1'b0;
        release_n = 1'b0;

        if (bus.mode != mode_q) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == HELD) begin
                release_n = 1'b1;
                dir_n     = '0;
                hit_idx_n = '0;
            end
        end else if (bus.touch_valid) begin
            case (state)
                IDLE: begin
                    if (sample_hit) begin
                        cand_n = match_idx;
                        cnt_n  = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_n   = HELD;
                            cnt_n     = '0;
                            press_n   = 1'b1;
                            dir_n     = onehot(match_idx);
                            hit_idx_n = match_idx;
                        end else begin
                            state_n = ARMING;
                        end
                    end
                end
                ARMING: begin
                    if (sample_hit && (match_idx == cand)) begin
                        if (at_limit) begin
                            state_n   = HELD;
                            cnt_n     = '0;
                            press_n   = 1'b1;
                            dir_n     = onehot(cand);
                            hit_idx_n = cand;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (sample_hit) begin
                        cand_n = match_idx;
                        cnt_n  = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (sample_hit && (match_idx == cand)) begin
                        cnt_n = '0;
                    end else if (at_limit) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        release_n = 1'b1;
                        dir_n     = '0;
                        hit_idx_n = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign bus.dir           = dir_q;
    assign bus.hit_idx       = hit_idx_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_touch_region_decoder.sv
// Scoreboard bench for touch_region_decoder in three parameterisations.
module tb_touch_region_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    touch_region_decoder_if #(.COORD_W(8),  .N_REGIONS(4)) ifa ();
    touch_region_decoder_if #(.COORD_W(10), .N_REGIONS(8)) ifb ();
    touch_region_decoder_if #(.COORD_W(8),  .N_REGIONS(5)) ifc ();

    touch_region_decoder #(.COORD_W(8),  .N_REGIONS(4), .DEBOUNCE(4)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    touch_region_decoder #(.COORD_W(10), .N_REGIONS(8), .DEBOUNCE(1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));
    touch_region_decoder #(.COORD_W(8),  .N_REGIONS(5), .DEBOUNCE(1)) dut_c (
        .clk (clk), .rst (rst), .bus (ifc.slave));

    typedef struct {
        int          sel;
        logic [31:0] dir;
        logic [31:0] idx;
        logic        press;
        logic        rel;
        string       tag;
    } exp_t;

    exp_t exp_q [$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    task automatic check_outs(input string tag, input logic [31:0] d, input logic [31:0] i,
                              input logic p, input logic r,
                              input logic [31:0] ed, input logic [31:0] ei,
                              input logic ep, input logic er);
        check_eq({tag, "_dir"}, d, ed);
        check_eq({tag, "_idx"}, i, ei);
        check_eq({tag, "_press"}, 32'(p), 32'(ep));
        check_eq({tag, "_release"}, 32'(r), 32'(er));
    endtask

    task automatic check_dut(input int sel, input string tag, input logic [31:0] ed,
                             input logic [31:0] ei, input logic ep, input logic er);
        case (sel)
            0: check_outs(tag, 32'(ifa.dir), 32'(ifa.hit_idx), ifa.press, ifa.release_pulse, ed, ei, ep, er);
            1: check_outs(tag, 32'(ifb.dir), 32'(ifb.hit_idx), ifb.press, ifb.release_pulse, ed, ei, ep, er);
            default: check_outs(tag, 32'(ifc.dir), 32'(ifc.hit_idx), ifc.press, ifc.release_pulse, ed, ei, ep, er);
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check_dut(cur.sel, cur.tag, cur.dir, cur.idx, cur.press, cur.rel);
        end
    end

    task automatic drive_idle();
        ifa.touch_valid = 1'b0; ifa.cfg_we = 1'b0;
        ifb.touch_valid = 1'b0; ifb.cfg_we = 1'b0;
        ifc.touch_valid = 1'b0; ifc.cfg_we = 1'b0;
    endtask

    task automatic step(input int sel, input bit valid, input bit pen, input int x, input int y,
                        input int edir, input int eidx, input bit ep, input bit er, input string tag);
        exp_t e;
        @(negedge clk);
        drive_idle();
        case (sel)
            0: begin ifa.touch_valid = valid; ifa.touch_pen = pen; ifa.touch_x = 8'(x);  ifa.touch_y = 8'(y);  end
            1: begin ifb.touch_valid = valid; ifb.touch_pen = pen; ifb.touch_x = 10'(x); ifb.touch_y = 10'(y); end
            default: begin ifc.touch_valid = valid; ifc.touch_pen = pen; ifc.touch_x = 8'(x); ifc.touch_y = 8'(y); end
        endcase
        e.sel = sel; e.dir = 32'(edir); e.idx = 32'(eidx); e.press = ep; e.rel = er; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic rep(input int sel, input int n, input bit pen, input int x, input int y,
                       input int edir, input int eidx, input string tag);
        for (int k = 0; k < n; k++) step(sel, 1'b1, pen, x, y, edir, eidx, 1'b0, 1'b0, tag);
    endtask

    task automatic set_mode(input int sel, input bit m, input int edir, input int eidx,
                            input bit er, input string tag);
        exp_t e;
        @(negedge clk);
        drive_idle();
        case (sel)
            0: ifa.mode = m;
            1: ifb.mode = m;
            default: ifc.mode = m;
        endcase
        e.sel = sel; e.dir = 32'(edir); e.idx = 32'(eidx); e.press = 1'b0; e.rel = er; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input int sel, input bit bank, input int idx, input bit en,
                       input int xmin, input int xmax, input int ymin, input int ymax);
        @(negedge clk);
        drive_idle();
        case (sel)
            0: begin
                ifa.cfg_we = 1'b1; ifa.cfg_bank = bank; ifa.cfg_idx = 2'(idx); ifa.cfg_en = en;
                ifa.cfg_xmin = 8'(xmin); ifa.cfg_xmax = 8'(xmax); ifa.cfg_ymin = 8'(ymin); ifa.cfg_ymax = 8'(ymax);
            end
            1: begin
                ifb.cfg_we = 1'b1; ifb.cfg_bank = bank; ifb.cfg_idx = 3'(idx); ifb.cfg_en = en;
                ifb.cfg_xmin = 10'(xmin); ifb.cfg_xmax = 10'(xmax); ifb.cfg_ymin = 10'(ymin); ifb.cfg_ymax = 10'(ymax);
            end
            default: begin
                ifc.cfg_we = 1'b1; ifc.cfg_bank = bank; ifc.cfg_idx = 3'(idx); ifc.cfg_en = en;
                ifc.cfg_xmin = 8'(xmin); ifc.cfg_xmax = 8'(xmax); ifc.cfg_ymin = 8'(ymin); ifc.cfg_ymax = 8'(ymax);
            end
        endcase
    endtask

    task automatic init_if();
        ifa.mode = 1'b0; ifa.touch_pen = 1'b0; ifa.touch_x = '0; ifa.touch_y = '0;
        ifa.cfg_bank = 1'b0; ifa.cfg_idx = '0; ifa.cfg_en = 1'b0;
        ifa.cfg_xmin = '0; ifa.cfg_xmax = '0; ifa.cfg_ymin = '0; ifa.cfg_ymax = '0;
        ifb.mode = 1'b0; ifb.touch_pen = 1'b0; ifb.touch_x = '0; ifb.touch_y = '0;
        ifb.cfg_bank = 1'b0; ifb.cfg_idx = '0; ifb.cfg_en = 1'b0;
        ifb.cfg_xmin = '0; ifb.cfg_xmax = '0; ifb.cfg_ymin = '0; ifb.cfg_ymax = '0;
        ifc.mode = 1'b0; ifc.touch_pen = 1'b0; ifc.touch_x = '0; ifc.touch_y = '0;
        ifc.cfg_bank = 1'b0; ifc.cfg_idx = '0; ifc.cfg_en = 1'b0;
        ifc.cfg_xmin = '0; ifc.cfg_xmax = '0; ifc.cfg_ymin = '0; ifc.cfg_ymax = '0;
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        init_if();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) check_dut(s, "reset", 0, 0, 1'b0, 1'b0);

        // Basic press and release on normal-bank region 0.
        cfg(0, 1'b0, 0, 1'b1, 69, 142, 13, 50);
        rep(0, 3, 1'b1, 100, 30, 0, 0, "arm");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b1, 1'b0, "press");
        step(0, 1'b0, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0, "gap");
        rep(0, 3, 1'b1, 0, 0, 1, 0, "unarm");
        step(0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b1, "release");
        step(0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, "rel_clear");

        // Strict bounds.
        rep(0, 4, 1'b1, 69, 30, 0, 0, "bnd_xmin");
        rep(0, 4, 1'b1, 142, 30, 0, 0, "bnd_xmax");
        rep(0, 4, 1'b1, 100, 13, 0, 0, "bnd_ymin");
        rep(0, 3, 1'b1, 70, 30, 0, 0, "bnd_in");
        step(0, 1'b1, 1'b1, 70, 30, 1, 0, 1'b1, 1'b0, "bnd_press");
        rep(0, 3, 1'b0, 100, 30, 1, 0, "pen_off");
        step(0, 1'b1, 1'b0, 100, 30, 0, 0, 1'b0, 1'b1, "pen_rel");

        // Overlap priority and candidate restart.
        cfg(0, 1'b0, 1, 1'b1, 50, 150, 50, 150);
        cfg(0, 1'b0, 2, 1'b1, 60, 140, 60, 140);
        cfg(0, 1'b0, 3, 1'b1, 200, 250, 200, 250);
        rep(0, 3, 1'b1, 100, 100, 0, 0, "ovl_arm");
        step(0, 1'b1, 1'b1, 100, 100, 2, 1, 1'b1, 1'b0, "ovl_press");
        rep(0, 3, 1'b1, 0, 0, 2, 1, "ovl_unarm");
        step(0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b1, "ovl_rel");
        rep(0, 3, 1'b1, 100, 100, 0, 0, "r1_arm");
        rep(0, 3, 1'b1, 220, 220, 0, 0, "r3_restart");
        step(0, 1'b1, 1'b1, 220, 220, 8, 3, 1'b1, 1'b0, "r3_press");
        rep(0, 3, 1'b1, 0, 0, 8, 3, "r3_unarm");
        step(0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b1, "r3_rel");

        // Mode change releases; battle bank is separate.
        rep(0, 3, 1'b1, 100, 30, 0, 0, "m_arm");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b1, 1'b0, "m_press");
        set_mode(0, 1'b1, 0, 0, 1'b1, "mode_rel");
        step(0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, "mode_clr");
        cfg(0, 1'b1, 2, 1'b1, 10, 60, 10, 60);
        rep(0, 3, 1'b1, 30, 30, 0, 0, "bat_arm");
        step(0, 1'b1, 1'b1, 30, 30, 4, 2, 1'b1, 1'b0, "bat_press");
        set_mode(0, 1'b0, 0, 0, 1'b1, "mode_back");
        rep(0, 4, 1'b1, 30, 30, 0, 0, "bank_sel");

        // Held region survives a short run of non-matching samples.
        rep(0, 3, 1'b1, 100, 30, 0, 0, "h_arm");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b1, 1'b0, "h_press");
        rep(0, 3, 1'b1, 0, 0, 1, 0, "h_miss");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b0, 1'b0, "h_keep");
        rep(0, 3, 1'b1, 220, 220, 1, 0, "h_other");
        step(0, 1'b1, 1'b1, 220, 220, 0, 0, 1'b0, 1'b1, "h_rel");

        // Immediate commit with DEBOUNCE=1, wider coordinates.
        cfg(1, 1'b0, 7, 1'b1, 500, 900, 500, 900);
        step(1, 1'b1, 1'b1, 800, 800, 'h80, 7, 1'b1, 1'b0, "b_press");
        step(1, 1'b1, 1'b1, 800, 800, 'h80, 7, 1'b0, 1'b0, "b_hold");
        step(1, 1'b1, 1'b1, 900, 800, 0, 0, 1'b0, 1'b1, "b_rel");

        // Out-of-range index ignored; config write does not release by itself.
        cfg(2, 1'b0, 5, 1'b1, 50, 150, 50, 150);
        step(2, 1'b1, 1'b1, 100, 100, 0, 0, 1'b0, 1'b0, "c_oob");
        cfg(2, 1'b0, 4, 1'b1, 50, 150, 50, 150);
        step(2, 1'b1, 1'b1, 100, 100, 'h10, 4, 1'b1, 1'b0, "c_idx4");
        cfg(2, 1'b0, 4, 1'b1, 0, 10, 0, 10);
        step(2, 1'b0, 1'b0, 0, 0, 'h10, 4, 1'b0, 1'b0, "c_cfg_hold");
        step(2, 1'b1, 1'b1, 100, 100, 0, 0, 1'b0, 1'b1, "c_cfg_rel");

        // Asynchronous reset while held.
        rep(0, 3, 1'b1, 100, 30, 0, 0, "r_arm");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b1, 1'b0, "r_press");
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b1;
        #1 check_dut(0, "async_rst", 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_dut(0, "rst_hold", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rep(0, 4, 1'b1, 100, 30, 0, 0, "tbl_cleared");

        // Reset mid-ARMING clears the count.
        cfg(0, 1'b0, 0, 1'b1, 69, 142, 13, 50);
        rep(0, 2, 1'b1, 100, 30, 0, 0, "ra_arm");
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b1;
        #1 check_dut(0, "arm_rst", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cfg(0, 1'b0, 0, 1'b1, 69, 142, 13, 50);
        rep(0, 3, 1'b1, 100, 30, 0, 0, "ra_rearm");
        step(0, 1'b1, 1'b1, 100, 30, 1, 0, 1'b1, 1'b0, "ra_press");

        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
